// File: rtl/led_fade_driver.sv
// led_fade_driver: per-channel brightness fader with PWM rendering.
// Each LED bit ramps its level toward full-on or off at a fixed rate.
// A shared PWM counter renders each channel's latched duty onto its pin.

// One channel: fade level, duty latch and registered PWM compare.
module led_fade_lane #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ENABLE,
    input  logic                tick,
    input  logic                latch,
    input  logic                in_bit,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic [PWM_BITS-1:0] duty,
    output logic                led,
    output logic                busy
);
    localparam int MAX = 2**PWM_BITS - 1;
    localparam logic [PWM_BITS:0] MAX_W  = (PWM_BITS+1)'(MAX);
    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS+1)'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] MAX_N = MAX_W[PWM_BITS-1:0];

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   dn_diff;
    logic [PWM_BITS-1:0] level_nxt;

    assign target = in_bit ? MAX_N : '0;
    assign busy   = (level != target);

    // Saturating step toward target; the extra bit catches overflow/borrow.
    always_comb begin
        up_sum    = {1'b0, level} + STEP_W;
        dn_diff   = {1'b0, level} - STEP_W;
        level_nxt = level;
        if (level != target) begin
            if (in_bit)
                level_nxt = (up_sum > MAX_W) ? MAX_N : up_sum[PWM_BITS-1:0];
            else
                level_nxt = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
        end
    end

    // Level on fade tick, duty at period end (old level wins a same-cycle tick), PWM out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level <= '0;
            duty  <= '0;
            led   <= 1'b0;
        end else begin
            if (tick)
                level <= level_nxt;
            if (latch)
                duty <= level;
            led <= ENABLE && ((duty == MAX_N) || (pwm_cnt < duty));
        end
    end
endmodule

module led_fade_driver #(
    parameter int WIDTH     = 8,
    parameter int PWM_BITS  = 8,
    parameter int STEP_DIV  = 64,
    parameter int FADE_STEP = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] LED_IN,
    input  logic             ENABLE,
    output logic [WIDTH-1:0] LED_OUT,
    output logic             PWM_SYNC,
    output logic             BUSY
);
    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    logic [WIDTH-1:0]                 in_r;
    logic [PS_W-1:0]                  prescaler;
    logic [PWM_BITS-1:0]              pwm_cnt;
    logic [WIDTH-1:0][PWM_BITS-1:0]   level_q;
    logic [WIDTH-1:0][PWM_BITS-1:0]   duty_q;
    logic [WIDTH-1:0]                 busy_v;
    logic                             tick;
    logic                             latch;

    assign tick  = ENABLE && (prescaler == PS_LAST);
    assign latch = ENABLE && (pwm_cnt == PWM_MAX);
    assign BUSY  = |busy_v;

    // Input sample (always), prescaler and PWM counter (only while enabled), sync pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_r      <= '0;
            prescaler <= '0;
            pwm_cnt   <= '0;
            PWM_SYNC  <= 1'b0;
        end else begin
            in_r <= LED_IN;
            if (ENABLE) begin
                prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
                pwm_cnt   <= pwm_cnt + 1'b1;
            end
            PWM_SYNC <= ENABLE && (pwm_cnt == '0);
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            led_fade_lane #(
                .PWM_BITS  (PWM_BITS),
                .FADE_STEP (FADE_STEP)
            ) u_lane (
                .CLK     (CLK),
                .RST     (RST),
                .ENABLE  (ENABLE),
                .tick    (tick),
                .latch   (latch),
                .in_bit  (in_r[i]),
                .pwm_cnt (pwm_cnt),
                .level   (level_q[i]),
                .duty    (duty_q[i]),
                .led     (LED_OUT[i]),
                .busy    (busy_v[i])
            );
        end
    endgenerate
endmodule
